uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter (Tx unit, Busy/TxD_start handshake) between NUM_REQ word producers, e.g. the FIR result path and a status/echo path.
- Grants one requester at a time, round-robin.
- Latches its WORD_WIDTH-bit word and serialises it MSB-byte-first into the Tx unit, one handshake per byte.
- Sits between the producers and the Tx/Baud_Rate_Generator pair in the system top.

Parameters:
- NUM_REQ, 2: number of requesters (>=2).
- WORD_WIDTH, 16: bits per request word; must be a multiple of UART_BITS.
- UART_BITS, 8: bits per UART character.
- Localparams: BYTES = WORD_WIDTH/UART_BITS; ID_W = max(1, LOG2_CEIL(NUM_REQ)); CNT_W = max(1, LOG2_CEIL(BYTES)).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i holds a word; must stay high with stable data until accepted.
- req_data  in  NUM_REQ*WORD_WIDTH  word i occupies bits [(i+1)*WORD_WIDTH-1 : i*WORD_WIDTH].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse; the word is taken when valid&ready.
- TxD_data  out  UART_BITS  byte presented to the Tx unit.
- TxD_start  out  1  start request to the Tx unit.
- Busy  in  1  Tx unit busy flag.
- grant_id  out  ID_W  index of the requester being served; holds the last value when idle.
- active  out  1  high from accept until the last byte completes.

Behaviour:
- Reset values (async, immediate): state=IDLE, req_ready=0, TxD_start=0, TxD_data=0, grant_id=0, active=0, byte counter=0, shift register=0, rr pointer=NUM_REQ-1 (requester 0 wins first).
- States:
  - IDLE: if any req_valid, grant the first valid index searching from ptr+1 modulo NUM_REQ. In the same cycle: pulse req_ready[g], load shift reg with word g, set grant_id=g, ptr=g, counter=0, active=1; go to SEND. Otherwise stay in IDLE.
  - SEND: TxD_start = (state==SEND) & ~Busy (combinational from state reg). If Busy=0, go to WAIT_HI; else stay in SEND.
  - WAIT_HI: wait for Busy=1, then go to WAIT_LO. A missed rise is a Tx-unit fault; no timeout.
  - WAIT_LO: wait for Busy=0. On the fall:
    - if counter==BYTES-1, go to IDLE and clear active;
    - else shift the register left by UART_BITS, increment the counter, go to SEND.
- TxD_data always equals the top UART_BITS of the shift register (MSB byte first). It is stable from SEND through WAIT_LO.
- Latency: request seen in IDLE at cycle 0 -> req_ready at cycle 0 -> TxD_start at cycle 1 if Busy=0.
- After the last byte's Busy fall, IDLE can accept a new word on the next cycle.
- No request is accepted while active. Producers stall with valid held; no data is dropped.
- Simultaneous requests: exactly one req_ready bit per accept. With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- req_valid falling before accept withdraws the request without error.
- req_valid of the granted requester going low after accept has no effect.
- Reset mid-word abandons the word; no partial-word resume. The Tx unit is reset by the same rst.
- TxD_start is asserted at most one cycle per byte.

Decomposition:
- Shared include (macros.v): LOG2_CEIL.
- Shared package/header: state encodings IDLE=0, SEND=1, WAIT_HI=2, WAIT_LO=3 (2-bit) and the UART_BITS default.
- One natural sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, pointer. Outputs: one-hot grant and grant index. Purely combinational; the pointer register stays in the scheduler.

Test Plan:
1. Single word: req_valid=01, word0=16'hA55A, Tx model raises Busy 1 cycle after start and holds it 10 cycles -> req_ready=01 for one cycle, TxD_start pulses twice, TxD_data=8'hA5 then 8'h5A, active drops after the second Busy fall.
2. Contention: req_valid=11 from reset, word0=16'h1234, word1=16'hBEEF, both held until accepted -> bytes in order 12,34,BE,EF; grant_id 0 then 1.
3. Fairness: NUM_REQ=3, all valid continuously for 6 words -> grant sequence 0,1,2,0,1,2 with no requester starved.
4. Busy already high at grant: hold Busy=1 for 5 cycles after accept -> TxD_start stays 0 until Busy=0, then pulses exactly once.
5. Async reset mid-word: assert rst during WAIT_LO of byte 0 -> all outputs 0 immediately (before the next clk edge). After release, a pending request is re-granted starting from requester 0.
6. Withdrawal: req_valid[1] pulses high for one cycle while active -> never granted, no req_ready[1] pulse.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, default
// character width and the width helper used for counter/index sizing.
package uart_tx_scheduler_pkg;

  localparam int UART_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  // ceil(log2(value)), never below 1 so single-entry fields stay legal vectors.
  function automatic int log2_ceil_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after the
// pointer, wrapping modulo NUM_REQ. The pointer register lives in the caller.
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = log2_ceil_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        any_o       = 1'b1;
        grant_o     = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Tx unit between NUM_REQ word producers: round-robin accept,
// then feeds the latched word MSB byte first through the Busy/TxD_start handshake.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WORD_WIDTH = 16,
  parameter int UART_BITS  = UART_BITS_DEFAULT,
  localparam int BYTES     = WORD_WIDTH / UART_BITS,
  localparam int ID_W      = log2_ceil_min1(NUM_REQ),
  localparam int CNT_W     = log2_ceil_min1(BYTES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [UART_BITS-1:0]          TxD_data,
  output logic                          TxD_start,
  input  logic                          Busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active
);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic                  active_q, active_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]       arb_idx;
  logic                  arb_any;
  logic [WORD_WIDTH-1:0] words [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) words[i] = req_data[i*WORD_WIDTH +: WORD_WIDTH];
  end

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    active_d  = active_q;
    req_ready = '0;
    TxD_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          // The accept pulse is combinational, so hold it off while in reset.
          req_ready = rst ? '0 : arb_grant;
          shift_d   = words[arb_idx];
          grant_d   = arb_idx;
          ptr_d     = arb_idx;
          cnt_d     = '0;
          active_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        TxD_start = ~Busy;
        if (!Busy) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (Busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!Busy) begin
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            shift_d = shift_q << UART_BITS;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  // NOTE: the shift register is reset too, because TxD_data is read straight
  // from it and must be 0 during and after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= ID_W'(NUM_REQ - 1);
      grant_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      active_q <= active_d;
    end
  end

  assign TxD_data = shift_q[WORD_WIDTH-1 -: UART_BITS];
  assign grant_id = grant_q;
  assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler: a behavioural Tx unit drives Busy and a
// queue-based model predicts accepts, grant order and the byte stream.
module tb_uart_tx_scheduler;

  localparam int N     = 3;
  localparam int W     = 16;
  localparam int UB    = 8;
  localparam int BYTES = W / UB;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [UB-1:0]    TxD_data;
  logic             TxD_start;
  logic             Busy;
  logic [ID_W-1:0]  grant_id;
  logic             active;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ    (N),
    .WORD_WIDTH (W),
    .UART_BITS  (UB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .TxD_data  (TxD_data),
    .TxD_start (TxD_start),
    .Busy      (Busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit         m_active;
  int         m_grant;
  int         m_last;
  bit         done_pending;
  int         bytes_left;
  logic [7:0] exp_bytes[$];
  int         grant_log[$];
  int         words_acc = 0;
  int         starts_cnt = 0;
  int         ready1_cnt = 0;
  bit [N-1:0] acc_prev;
  int         policy;

  // Behavioural Tx unit
  bit tx_busy, pending, force_busy, hold_rand;
  int hold_left, hold_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (((v >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_word(input int i, input logic [W-1:0] w);
    logic [N*W-1:0] mask;
    mask     = (N*W)'({W{1'b1}}) << (i*W);
    req_data = (req_data & ~mask) | ((N*W)'(w) << (i*W));
  endtask

  task automatic set_valid(input int i, input bit v);
    logic [N-1:0] m;
    m         = N'(1) << i;
    req_valid = v ? (req_valid | m) : (req_valid & ~m);
  endtask

  task automatic step_begin();
    @(negedge clk);
    if (done_pending) begin
      m_active     = 1'b0;
      done_pending = 1'b0;
    end
    if (tx_busy) begin
      if (hold_left <= 1) begin
        tx_busy = 1'b0;
        if (bytes_left == 0) done_pending = 1'b1;
      end else hold_left--;
    end else if (pending) begin
      tx_busy   = 1'b1;
      pending   = 1'b0;
      hold_left = hold_rand ? int'($urandom_range(1, 6)) : hold_len;
    end
    Busy = tx_busy | force_busy;
  endtask

  task automatic step_end();
    logic [N-1:0]    o_ready;
    logic            o_start, o_active, o_busy;
    logic [7:0]      o_data;
    logic [ID_W-1:0] o_gid;
    logic [W-1:0]    w;
    int              g;
    #1;
    o_ready  = req_ready;
    o_start  = TxD_start;
    o_active = active;
    o_busy   = Busy;
    o_data   = TxD_data;
    o_gid    = grant_id;
    g = m_active ? -1 : rr_pick(req_valid, m_last);
    check("req_ready", 32'(o_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    check("active", 32'(o_active), 32'(m_active));
    check("grant_id", 32'(o_gid), 32'(m_grant));
    if (o_start) begin
      starts_cnt++;
      check("start_while_busy", 32'(o_busy), 32'd0);
      if (exp_bytes.size() == 0) check("spurious_start", 32'(o_start), 32'd0);
      else check("tx_byte", 32'(o_data), 32'(exp_bytes.pop_front()));
      pending = 1'b1;
      bytes_left--;
    end
    if (((o_ready >> 1) & 1) != 0) ready1_cnt++;
    for (int i = 0; i < N; i++) if (((o_ready >> i) & 1) != 0) grant_log.push_back(i);
    acc_prev = '0;
    if (g >= 0) begin
      m_active = 1'b1;
      m_grant  = g;
      m_last   = g;
      w        = W'(req_data >> (g*W));
      for (int b = 0; b < BYTES; b++) exp_bytes.push_back(8'(w >> ((BYTES - 1 - b) * UB)));
      bytes_left = BYTES;
      acc_prev   = N'(1) << g;
      words_acc++;
    end
  endtask

  task automatic step();
    step_begin();
    for (int i = 0; i < N; i++) begin
      bit acc, vld;
      acc = ((acc_prev >> i) & 1) != 0;
      vld = ((req_valid >> i) & 1) != 0;
      case (policy)
        0: if (acc) set_valid(i, 1'b0);
        1: if (acc) set_word(i, W'($urandom));
        2: begin
          if (acc) begin
            set_word(i, W'($urandom));
            set_valid(i, 1'($urandom_range(0, 1)));
          end else if (vld) begin
            if ($urandom_range(0, 15) == 0) set_valid(i, 1'b0);
          end else if ($urandom_range(0, 3) == 0) begin
            set_word(i, W'($urandom));
            set_valid(i, 1'b1);
          end
        end
        default: set_valid(i, 1'b0);
      endcase
    end
    step_end();
  endtask

  task automatic run_words(input string tag, input int target, input int budget, input bit wait_idle);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      step();
      cyc++;
      done = (words_acc >= target) && (!wait_idle || (!m_active && exp_bytes.size() == 0));
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset(input bit keep);
    rst = 1'b1;
    if (!keep) req_valid = '0;
    m_active     = 1'b0;
    m_grant      = 0;
    m_last       = N - 1;
    done_pending = 1'b0;
    bytes_left   = 0;
    exp_bytes.delete();
    grant_log.delete();
    tx_busy      = 1'b0;
    pending      = 1'b0;
    force_busy   = 1'b0;
    Busy         = 1'b0;
    acc_prev     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step_end();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '0;
    Busy      = 1'b0;
    policy    = 0;
    hold_len  = 10;
    hold_rand = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_txd_start", 32'(TxD_start), 32'd0);
    check("rst_txd_data", 32'(TxD_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    do_reset(1'b0);

    // Single word, 10-cycle Busy
    starts_cnt = 0;
    base = words_acc;
    step_begin();
    set_word(0, 16'hA55A);
    set_valid(0, 1'b1);
    step_end();
    run_words("single", base + 1, 200, 1'b1);
    check("single_starts", 32'(starts_cnt), 32'(BYTES));
    check("single_grant_cnt", 32'(grant_log.size()), 32'd1);
    check("single_grant_id", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

    // Contention between requesters 0 and 1
    do_reset(1'b0);
    hold_rand = 1'b1;
    base = words_acc;
    step_begin();
    set_word(0, 16'h1234);
    set_word(1, 16'hBEEF);
    set_valid(0, 1'b1);
    set_valid(1, 1'b1);
    step_end();
    run_words("contention", base + 2, 300, 1'b1);
    check("contention_cnt", 32'(grant_log.size()), 32'd2);
    for (int i = 0; i < grant_log.size() && i < 2; i++) check("contention_order", 32'(grant_log[i]), 32'(i));

    // Fairness with all requesters continuously valid
    do_reset(1'b0);
    policy = 1;
    base = words_acc;
    step_begin();
    for (int i = 0; i < N; i++) begin
      set_word(i, W'($urandom));
      set_valid(i, 1'b1);
    end
    step_end();
    run_words("fairness", base + 6, 2000, 1'b0);
    for (int i = 0; i < grant_log.size() && i < 6; i++) check("fairness_order", 32'(grant_log[i]), 32'(i % N));
    policy = 3;
    run_words("fairness_drain", words_acc, 500, 1'b1);

    // Busy already high at grant
    do_reset(1'b0);
    policy = 0;
    hold_rand = 1'b0;
    hold_len = 3;
    force_busy = 1'b1;
    starts_cnt = 0;
    base = words_acc;
    step_begin();
    set_word(0, W'($urandom));
    set_valid(0, 1'b1);
    step_end();
    repeat (5) step();
    check("busy_hold_no_start", 32'(starts_cnt), 32'd0);
    force_busy = 1'b0;
    run_words("busy_hold", base + 1, 200, 1'b1);
    check("busy_hold_starts", 32'(starts_cnt), 32'(BYTES));

    // Async reset in WAIT_LO of byte 0
    do_reset(1'b0);
    policy = 1;
    hold_len = 8;
    step_begin();
    set_word(0, W'($urandom));
    set_word(1, W'($urandom));
    set_valid(0, 1'b1);
    set_valid(1, 1'b1);
    step_end();
    for (int c = 0; c < 100 && !(tx_busy && bytes_left == BYTES - 1); c++) step();
    step();
    check("mid_word_active", 32'(active), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_req_ready", 32'(req_ready), 32'd0);
    check("async_txd_start", 32'(TxD_start), 32'd0);
    check("async_txd_data", 32'(TxD_data), 32'd0);
    check("async_grant_id", 32'(grant_id), 32'd0);
    check("async_active", 32'(active), 32'd0);
    do_reset(1'b1);
    check("reset_regrant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
    policy = 3;
    run_words("reset_drain", words_acc, 500, 1'b1);

    // Withdrawn one-cycle request while busy
    do_reset(1'b0);
    policy = 0;
    hold_len = 4;
    ready1_cnt = 0;
    base = words_acc;
    step_begin();
    set_word(0, W'($urandom));
    set_valid(0, 1'b1);
    step_end();
    step();
    step();
    step_begin();
    set_word(1, W'($urandom));
    set_valid(1, 1'b1);
    step_end();
    step_begin();
    set_valid(1, 1'b0);
    step_end();
    run_words("withdraw", base + 1, 200, 1'b1);
    check("withdraw_ready1", 32'(ready1_cnt), 32'd0);
    check("withdraw_words", 32'(words_acc - base), 32'd1);

    // Random traffic
    do_reset(1'b0);
    policy = 2;
    hold_rand = 1'b1;
    base = words_acc;
    repeat (600) step();
    policy = 3;
    run_words("random_drain", words_acc, 1000, 1'b1);
    check("random_traffic", 32'(words_acc - base > 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
